frame_writer: RTL and testbench

//  Stream sink that terminates a dstream pixel stream, such as conv_filter's y output, and writes it to a frame buffer.

---
 rtl/video_pkg.sv | 16 +
 rtl/dstream_if.sv | 24 ++
 rtl/raster_counter.sv | 69 ++++++
 rtl/frame_writer.sv | 128 ++++++++++++
 tb/tb_frame_writer.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared video types and frame geometry for the frame buffer write/read path.
package video_pkg;

  localparam int FRAME_W      = 320;
  localparam int FRAME_H      = 240;
  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
  localparam int PIX_W        = 30;

  typedef enum logic [0:0] {
    IDLE,
    WRITE
  } fw_state_t;

  typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/dstream_if.sv
// Valid/ready pixel stream; the master drives data/valid, the slave (sink) drives ready.
interface dstream
  import video_pkg::*;
#(
  parameter int W = PIX_W
) ();

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/raster_counter.sv
// Raster position tracker: column, row and linear address of the current pixel.
module raster_counter
  import video_pkg::*;
#(
  parameter int WIDTH  = FRAME_W,
  parameter int HEIGHT = FRAME_H,
  parameter int ADDR_W = $clog2(WIDTH * HEIGHT),
  parameter int COL_W  = $clog2(WIDTH),
  parameter int ROW_W  = $clog2(HEIGHT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign last = (col_q == COL_W'(WIDTH - 1)) && (row_q == ROW_W'(HEIGHT - 1));

  // The address runs alongside col/row so no multiplier is needed; clear wins over advance.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (clear) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (advance) begin
      if (last) begin
        col_d  = '0;
        row_d  = '0;
        addr_d = '0;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
        if (col_q == COL_W'(WIDTH - 1)) begin
          col_d = '0;
          row_d = row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign addr = addr_q;

endmodule

// File: rtl/frame_writer.sv
// Pixel stream sink writing one frame into a linear frame buffer through a 1-entry beat register.
// Define FRAME_WRITER_CONT_EN for free-running capture (stay in WRITE and wrap after each frame).
module frame_writer
  import video_pkg::*;
#(
  parameter int W      = PIX_W,
  parameter int WIDTH  = FRAME_W,
  parameter int HEIGHT = FRAME_H,
  parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
  input  logic              clk,
  input  logic              rst_n,
  dstream.slave             x,
  input  logic              start,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [W-1:0]      wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frame_count
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);

  fw_state_t         state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [W-1:0]      wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        frame_count_q, frame_count_d;

  logic              x_ready;
  logic              xfer;
  logic              last;
  logic [ADDR_W-1:0] pix_addr;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              unused_raster;

  // The register may accept a new pixel whenever it is empty or its beat leaves this cycle.
  assign x_ready = (state_q == WRITE) && (!wr_en_q || wr_ready);
  assign xfer    = x.valid && x_ready;
  assign x.ready = x_ready;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W),
    .COL_W  (COL_W),
    .ROW_W  (ROW_W)
  ) u_raster (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start),
    .advance (xfer),
    .col     (col),
    .row     (row),
    .addr    (pix_addr),
    .last    (last)
  );

  assign unused_raster = ^{col, row};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
`ifdef FRAME_WRITER_CONT_EN
        state_d = WRITE;
`else
        if (xfer && last && !start) begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // A held beat stays frozen until wr_ready; a transfer reloads it in the same cycle it drains.
  always_comb begin
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (xfer) begin
      wr_en_d   = 1'b1;
      wr_addr_d = pix_addr;
      wr_data_d = x.data;
    end else if (wr_ready) begin
      wr_en_d = 1'b0;
    end
    frame_done_d  = xfer && last;
    frame_count_d = frame_count_q + {7'd0, frame_done_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = (state_q == WRITE);
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer on a 40x30 frame, with a scoreboard of expected write beats.
module tb_frame_writer;
  import video_pkg::*;

  localparam int TB_W = 40;
  localparam int TB_H = 30;
  localparam int PIX  = TB_W * TB_H;
  localparam int AW   = $clog2(PIX);
`ifdef FRAME_WRITER_CONT_EN
  localparam bit END_BUSY = 1'b1;
`else
  localparam bit END_BUSY = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    pixel_t        data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  pixel_t        wr_data;
  logic          wr_ready;
  logic          busy;
  logic          frame_done;
  logic [7:0]    frame_count;

  int checks = 0;
  int errors = 0;
  int tx_data = 0;
  int beats = 0;
  int dones = 0;

  beat_t         sb_q[$];
  beat_t         mon_b;
  int            exp_idx = 0;
  bit            exp_busy = 1'b0;
  bit            exp_wr_en = 1'b0;
  bit            prev_xfer = 1'b0;
  bit            prev_last = 1'b0;
  bit            mon_xfer;
  logic [AW-1:0] last_addr = '0;
  logic [7:0]    exp_count = 8'd0;

  dstream #(.W(PIX_W)) x_if ();

  frame_writer #(
    .W      (PIX_W),
    .WIDTH  (TB_W),
    .HEIGHT (TB_H),
    .ADDR_W (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x           (x_if),
    .start       (start),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  // Reference model and scoreboard, evaluated mid-cycle while inputs and outputs are stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_idx   = 0;
      exp_busy  = 1'b0;
      exp_wr_en = 1'b0;
      prev_xfer = 1'b0;
      prev_last = 1'b0;
      exp_count = 8'd0;
    end else begin
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("[TB] FAIL busy: got %b want %b at %0t", busy, exp_busy, $time);
      end
      checks++;
      if (wr_en !== exp_wr_en) begin
        errors++;
        $display("[TB] FAIL wr_en: got %b want %b at %0t", wr_en, exp_wr_en, $time);
      end
      checks++;
      if (x_if.ready !== (exp_busy && (!exp_wr_en || wr_ready))) begin
        errors++;
        $display("[TB] FAIL x_ready: got %b want %b at %0t", x_if.ready,
                 exp_busy && (!exp_wr_en || wr_ready), $time);
      end
      checks++;
      if (frame_done !== prev_last) begin
        errors++;
        $display("[TB] FAIL frame_done: got %b want %b at %0t", frame_done, prev_last, $time);
      end
      checks++;
      if (frame_count !== exp_count) begin
        errors++;
        $display("[TB] FAIL frame_count: got %0d want %0d at %0t", frame_count, exp_count, $time);
      end
      if (prev_xfer) begin
        checks++;
        if (wr_addr !== last_addr) begin
          errors++;
          $display("[TB] FAIL latency_addr: got %0d want %0d at %0t", wr_addr, last_addr, $time);
        end
      end
      if (wr_en && wr_ready) begin
        beats++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL extra_beat: got addr %0d want no beat at %0t", wr_addr, $time);
        end else begin
          mon_b = sb_q.pop_front();
          if (wr_addr !== mon_b.addr || wr_data !== mon_b.data) begin
            errors++;
            $display("[TB] FAIL beat: got addr %0d data %0h want addr %0d data %0h at %0t",
                     wr_addr, wr_data, mon_b.addr, mon_b.data, $time);
          end
        end
      end
      if (frame_done === 1'b1) dones++;

      mon_xfer  = (x_if.valid === 1'b1) && (x_if.ready === 1'b1);
      exp_wr_en = mon_xfer ? 1'b1 : (exp_wr_en && !wr_ready);
      prev_xfer = mon_xfer;
      prev_last = 1'b0;
      if (mon_xfer) begin
        last_addr  = AW'(exp_idx);
        mon_b.addr = AW'(exp_idx);
        mon_b.data = x_if.data;
        sb_q.push_back(mon_b);
        if (exp_idx == PIX - 1) begin
          prev_last = 1'b1;
          exp_count = exp_count + 8'd1;
          exp_idx   = 0;
          if (!END_BUSY) exp_busy = 1'b0;
        end else begin
          exp_idx++;
        end
      end
      if (start === 1'b1) begin
        exp_busy = 1'b1;
        exp_idx  = 0;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pixels(input int n, input int gap_pct);
    int sent   = 0;
    int cycles = 0;
    bit acc;
    while (sent < n && cycles < n * 20 + 100) begin
      x_if.valid = ($urandom_range(99) >= gap_pct);
      x_if.data  = pixel_t'(tx_data);
      @(negedge clk);
      acc = x_if.valid && x_if.ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        tx_data++;
      end
      cycles++;
    end
    x_if.valid = 1'b0;
    checks++;
    if (sent != n) begin
      errors++;
      $display("[TB] FAIL send_timeout: accepted %0d want %0d", sent, n);
    end
  endtask

  task automatic drain_and_check(input string name, input int beats0, input int want_beats,
                                 input int dones0, input int want_dones, input int want_count);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (beats - beats0 != want_beats) begin
      errors++;
      $display("[TB] FAIL %s_beats: got %0d want %0d", name, beats - beats0, want_beats);
    end
    checks++;
    if (dones - dones0 != want_dones) begin
      errors++;
      $display("[TB] FAIL %s_dones: got %0d want %0d", name, dones - dones0, want_dones);
    end
    checks++;
    if (frame_count !== 8'(want_count)) begin
      errors++;
      $display("[TB] FAIL %s_count: got %0d want %0d", name, frame_count, want_count);
    end
    checks++;
    if (busy !== END_BUSY) begin
      errors++;
      $display("[TB] FAIL %s_busy_end: got %b want %b", name, busy, END_BUSY);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_pending: got %0d beats left want 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    start      = 1'b0;
    wr_ready   = 1'b1;
    x_if.valid = 1'b0;
    x_if.data  = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({wr_en, busy, frame_done, x_if.ready} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b want 0000", {wr_en, busy, frame_done, x_if.ready});
    end
    checks++;
    if (wr_addr !== '0 || wr_data !== '0 || frame_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_values: got addr %0d data %0h count %0d want 0 0 0",
               wr_addr, wr_data, frame_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_no_start();
    x_if.valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if (x_if.ready !== 1'b0 || wr_en !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_ready: got ready %b wr_en %b want 0 0", x_if.ready, wr_en);
      end
      @(posedge clk); #1;
    end
    x_if.valid = 1'b0;
  endtask

  task automatic test_full_frame();
    int b0 = beats;
    int d0 = dones;
    tx_data = 0;
    pulse_start();
    send_pixels(PIX, 0);
    drain_and_check("full_frame", b0, PIX, d0, 1, 1);
  endtask

  task automatic test_backpressure();
    int b0 = beats;
    int d0 = dones;
    tx_data = 0;
    pulse_start();
    send_pixels(1001, 0);
    wr_ready   = 1'b0;
    x_if.valid = 1'b1;
    x_if.data  = pixel_t'(tx_data);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== AW'(1000) || wr_data !== pixel_t'(1000) ||
          x_if.ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hold: got en %b addr %0d data %0d ready %b want 1 1000 1000 0",
                 wr_en, wr_addr, wr_data, x_if.ready);
      end
      @(posedge clk); #1;
    end
    wr_ready = 1'b1;
    send_pixels(PIX - 1001, 0);
    drain_and_check("backpressure", b0, PIX, d0, 1, 2);
  endtask

  task automatic test_gaps();
    int b0 = beats;
    int d0 = dones;
    for (int f = 0; f < 2; f++) begin
      pulse_start();
      send_pixels(PIX, 30);
    end
    drain_and_check("gaps", b0, 2 * PIX, d0, 2, 4);
  endtask

  task automatic test_restart();
    int b0 = beats;
    int d0 = dones;
    pulse_start();
    send_pixels(500, 0);
    pulse_start();
    send_pixels(1, 0);
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== '0) begin
      errors++;
      $display("[TB] FAIL restart_addr: got en %b addr %0d want 1 0", wr_en, wr_addr);
    end
    @(posedge clk); #1;
    send_pixels(PIX - 1, 0);
    drain_and_check("restart", b0, 500 + PIX, d0, 1, 5);
  endtask

  task automatic test_reset_mid_frame();
    int b0;
    int d0;
    pulse_start();
    send_pixels(900, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_en, busy, frame_done, x_if.ready} !== 4'b0000 || wr_addr !== '0 ||
        wr_data !== '0 || frame_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got en %b busy %b done %b rdy %b addr %0d data %0h cnt %0d want all 0",
               wr_en, busy, frame_done, x_if.ready, wr_addr, wr_data, frame_count);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    b0 = beats;
    d0 = dones;
    pulse_start();
    send_pixels(1, 0);
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== '0) begin
      errors++;
      $display("[TB] FAIL post_reset_addr: got en %b addr %0d want 1 0", wr_en, wr_addr);
    end
    @(posedge clk); #1;
    send_pixels(PIX - 1, 0);
    drain_and_check("reset_mid", b0, PIX, d0, 1, 1);
  endtask

`ifdef FRAME_WRITER_CONT_EN
  task automatic test_continuous();
    int b0 = beats;
    int d0 = dones;
    send_pixels(2 * PIX, 10);
    drain_and_check("continuous", b0, 2 * PIX, d0, 2, 3);
  endtask
`endif

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_no_start();
    test_full_frame();
    test_backpressure();
    test_gaps();
    test_restart();
    test_reset_mid_frame();
`ifdef FRAME_WRITER_CONT_EN
    test_continuous();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
